// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants, coefficient type and sampler state encoding.
// Candidate assembly lives here so every ExpandA block forms it identically.
package dilithium_pkg;

    localparam int DILITHIUM_N = 256;
    localparam int DILITHIUM_Q = 8380417;
    localparam int COEFF_WIDTH = 24;

    typedef logic [COEFF_WIDTH-1:0] coeff_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } samp_state_t;

    // Top bit of the third byte is dropped: candidates are 23 bits.
    function automatic logic [22:0] cand_from_bytes(input logic [7:0] b0,
                                                    input logic [7:0] b1,
                                                    input logic [7:0] b2);
        return {b2[6:0], b1, b0};
    endfunction

endpackage

// File: rtl/rej_byte_buffer.sv
// Byte shift buffer: push a whole squeeze word behind the residual, pop 3 bytes from the head.
// Latency: pushed bytes visible the next cycle; push and pop are mutually exclusive by construction.
// Backpressure: none internally, the owner gates push on cnt.
module rej_byte_buffer #(
    parameter int IN_BYTES = 8,
    parameter int DEPTH    = IN_BYTES + 2,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [IN_BYTES*8-1:0] push_data,
    input  logic                  pop,
    output logic [7:0]            b0,
    output logic [7:0]            b1,
    output logic [7:0]            b2,
    output logic [CNT_W-1:0]      cnt
);

    logic [7:0]       bytes     [DEPTH];
    logic [7:0]       nxt_bytes [DEPTH];
    logic [CNT_W-1:0] nxt_cnt;

    always_comb begin
        nxt_bytes = bytes;
        nxt_cnt   = cnt;
        if (clr) begin
            nxt_cnt = '0;
        end else if (push) begin
            // New bytes land directly behind the residual, byte 0 first.
            for (int k = 0; k < DEPTH; k++) begin
                if ((k >= int'(cnt)) && (k < int'(cnt) + IN_BYTES)) begin
                    nxt_bytes[k] = push_data[8*(k-int'(cnt)) +: 8];
                end
            end
            nxt_cnt = cnt + CNT_W'(IN_BYTES);
        end else if (pop) begin
            for (int k = 0; k < DEPTH - 3; k++) begin
                nxt_bytes[k] = bytes[k+3];
            end
            nxt_cnt = cnt - CNT_W'(3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bytes <= '{default: '0};
            cnt   <= '0;
        end else begin
            bytes <= nxt_bytes;
            cnt   <= nxt_cnt;
        end
    end

    assign b0 = bytes[0];
    assign b1 = bytes[1];
    assign b2 = bytes[2];

endmodule

// File: rtl/rej_ntt_sampler.sv
// RejNTTPoly sampler: 3-byte candidates from the SHAKE128 stream, keep those below Q, emit N coefficients.
// Latency: word taken at t -> candidate evaluated t+1 -> coeff_valid t+2. Optional counters: REJ_SAMPLER_STATS_EN.
// Backpressure: coeff_ready low freezes the output register and stalls evaluation; in_ready only while cnt<3.
module rej_ntt_sampler
    import dilithium_pkg::*;
#(
    parameter int N            = DILITHIUM_N,
    parameter int COEFF_WIDTH  = dilithium_pkg::COEFF_WIDTH,
    parameter int DATA_IN_BITS = 64,
    parameter int Q            = DILITHIUM_Q
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_IN_BITS-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [COEFF_WIDTH-1:0]  coeff_data,
    output logic [$clog2(N)-1:0]    coeff_idx,
    output logic                    coeff_valid,
    input  logic                    coeff_ready,
    output logic                    busy,
`ifdef REJ_SAMPLER_STATS_EN
    output logic [15:0]             rej_cnt,
    output logic [15:0]             words_used,
`endif
    output logic                    done
);

    localparam int                 IN_BYTES  = DATA_IN_BITS / 8;
    localparam int                 BUF_DEPTH = IN_BYTES + 2;
    localparam int                 BUF_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int                 IDX_W     = $clog2(N);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N - 1);
    localparam logic [22:0]        Q_L       = 23'(Q);

    samp_state_t          state;
    logic [IDX_W-1:0]     acc;
    logic                 final_pending;

    logic [7:0]           b0, b1, b2;
    logic [BUF_CNT_W-1:0] buf_cnt;
    logic [22:0]          cand;
    logic                 cand_lt_q;
    logic                 clr, push, eval, accept, out_free;

    assign clr       = start && (state == ST_IDLE);
    assign in_ready  = (state == ST_RUN) && (buf_cnt < BUF_CNT_W'(3)) && !final_pending;
    assign push      = in_valid && in_ready;
    assign out_free  = !coeff_valid || coeff_ready;
    assign eval      = (state == ST_RUN) && !final_pending &&
                       (buf_cnt >= BUF_CNT_W'(3)) && out_free;
    assign cand      = cand_from_bytes(b0, b1, b2);
    assign cand_lt_q = cand < Q_L;
    assign accept    = eval && cand_lt_q;
    assign busy      = (state == ST_RUN);

    rej_byte_buffer #(
        .IN_BYTES (IN_BYTES),
        .DEPTH    (BUF_DEPTH),
        .CNT_W    (BUF_CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .push_data (in_data),
        .pop       (eval),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .cnt       (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            acc           <= '0;
            final_pending <= 1'b0;
            coeff_valid   <= 1'b0;
            coeff_data    <= '0;
            coeff_idx     <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_RUN;
                        acc           <= '0;
                        final_pending <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (coeff_valid && coeff_ready) begin
                        coeff_valid <= 1'b0;
                    end
                    if (accept) begin
                        coeff_data  <= COEFF_WIDTH'(cand);
                        coeff_idx   <= acc;
                        coeff_valid <= 1'b1;
                        // acc parks at N-1; final_pending marks the last load instead of a wrap.
                        if (acc == LAST_IDX) begin
                            final_pending <= 1'b1;
                        end else begin
                            acc <= acc + 1'b1;
                        end
                    end
                    if (final_pending && coeff_valid && coeff_ready) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef REJ_SAMPLER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_cnt    <= '0;
            words_used <= '0;
        end else if (clr) begin
            rej_cnt    <= '0;
            words_used <= '0;
        end else begin
            if (eval && !cand_lt_q && (rej_cnt != 16'hFFFF)) begin
                rej_cnt <= rej_cnt + 16'd1;
            end
            if (push) begin
                words_used <= words_used + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rej_ntt_sampler.sv
// Scoreboard bench for rej_ntt_sampler: a byte-stream reference model queues expected (idx, coeff) pairs
// on every accepted word; outputs are popped and compared at the falling edge.
module tb_rej_ntt_sampler;

    localparam int N = 256;
    localparam logic [22:0] QV = 23'd8380417;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_ready, coeff_valid, coeff_ready, busy, done;
    logic [63:0] in_data;
    logic [23:0] coeff_data;
    logic [7:0]  coeff_idx;
`ifdef REJ_SAMPLER_STATS_EN
    logic [15:0] rej_cnt, words_used;
`endif

    always #5 clk = ~clk;

    rej_ntt_sampler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .coeff_data  (coeff_data),
        .coeff_idx   (coeff_idx),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .busy        (busy),
`ifdef REJ_SAMPLER_STATS_EN
        .rej_cnt     (rej_cnt),
        .words_used  (words_used),
`endif
        .done        (done)
    );

    typedef struct packed {
        logic [7:0]  idx;
        logic [23:0] dat;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  mq[$];
    int          macc, mrej;
    int          n_checks = 0;
    int          n_fail   = 0;

    int          mode, polys_left, words_taken, valid_cycles, poly_hs;
    int          stall_left, stall_seen, rst_at, widx;
    bit          last_hs_prev, stall_en, rand_rdy, rand_vld, aborted, held_ok;
    logic [23:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [63:0] gen_word(input int m, input int i);
        logic [63:0] w;
        w = 64'h0;
        case (m)
            1: w = 64'hFFFF_FFFF_FFFF_FFFF;
            2: w = (i == 0) ? 64'h0005_7FE0_017F_E000 : ((i == 1) ? 64'h0000_0000_0000_0080 : 64'h0);
            3: w = (i == 0) ? 64'hBBAA_FFFF_FFFF_FFFF : ((i == 1) ? 64'h0000_0000_0000_0001 : 64'h0);
            4: begin
                w = {$urandom(), $urandom()};
                if ($urandom_range(0, 2) == 0) w = w | (64'hFF_FFFF << (8 * $urandom_range(0, 5)));
            end
            default: w = 64'h0;
        endcase
        return w;
    endfunction

    task automatic model_push(input logic [63:0] w);
        logic [7:0]  x0, x1, x2;
        logic [22:0] c;
        exp_t        e;
        for (int k = 0; k < 8; k++) mq.push_back(w[8*k +: 8]);
        while (mq.size() >= 3 && macc < N) begin
            x0 = mq.pop_front();
            x1 = mq.pop_front();
            x2 = mq.pop_front();
            c  = {x2[6:0], x1, x0};
            if (c < QV) begin
                e.idx = 8'(macc);
                e.dat = {1'b0, c};
                expq.push_back(e);
                macc++;
            end else begin
                mrej++;
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        expq.delete();
        macc        = 0;
        mrej        = 0;
        words_taken = 0;
        poly_hs     = 0;
    endtask

    task automatic cycle();
        bit   adv, last_hs, stall_go;
        exp_t e;
        adv = 0; last_hs = 0; stall_go = 0;
        @(negedge clk);
        if (rst_at >= 0 && coeff_valid && int'(coeff_idx) == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_vld",  coeff_valid, 0);
            chk("rst_dat",  coeff_data,  0);
            chk("rst_idx",  coeff_idx,   0);
            chk("rst_rdy",  in_ready,    0);
            chk("rst_busy", busy,        0);
            chk("rst_done", done,        0);
            aborted = 1;
            return;
        end
        chk("done", done, last_hs_prev);
        if (done) begin
            chk("busy_done", busy, 0);
            polys_left--;
        end
        if (coeff_valid) valid_cycles++;
        if (coeff_valid && coeff_idx == 8'd255) chk("rdy_final", in_ready, 0);
        if (stall_en && !coeff_ready && coeff_valid) begin
            stall_seen++;
            chk("stall_idx", coeff_idx, 7);
            if (held_ok) chk("stall_dat", coeff_data, held);
            else begin
                held    = coeff_data;
                held_ok = 1;
            end
            if (stall_seen >= 2) chk("stall_rdy", in_ready, 0);
        end
        if (coeff_valid && coeff_ready) begin
            chk("sb_avail", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("idx",  coeff_idx,  e.idx);
                chk("data", coeff_data, e.dat);
            end
            if (mode == 2 && poly_hs == 0) chk("q_minus_1", coeff_data, 24'd8380416);
            if (mode == 2 && poly_hs == 1) chk("after_q_rej", coeff_data, 24'd5);
            if (mode == 3 && poly_hs == 0) chk("straddle", coeff_data, 24'h01BBAA);
            poly_hs++;
            if (stall_en && coeff_idx == 8'd6) stall_go = 1;
            if (coeff_idx == 8'd255) last_hs = 1;
        end
        if (in_valid && in_ready) begin
            model_push(in_data);
            words_taken++;
            adv = 1;
        end
        @(posedge clk);
        #1;
        last_hs_prev = last_hs;
        start = 1'b0;
        if (last_hs && polys_left > 1) begin
            chk("sb_empty_chain", expq.size(), 0);
            model_reset();
            start = 1'b1;
        end
        if (adv) begin
            widx++;
            in_data = gen_word(mode, widx);
        end
        in_valid = rand_vld ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (stall_go) stall_left = 10;
        if (stall_left > 0) begin
            coeff_ready = 1'b0;
            stall_left--;
        end else begin
            coeff_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic run_poly(input int m, input int npoly, input int max_words);
        int cyc;
        mode = m; polys_left = npoly; widx = 0;
        model_reset();
        last_hs_prev = 0; aborted = 0; valid_cycles = 0;
        stall_seen = 0; held_ok = 0; stall_left = 0;
        in_data = gen_word(m, 0);
        in_valid = 1'b1;
        coeff_ready = 1'b1;
        start = 1'b1;
        cyc = 0;
        while (polys_left > 0 && !aborted && cyc < 6000 &&
               (max_words == 0 || words_taken < max_words)) begin
            cycle();
            cyc++;
        end
    endtask

    task automatic end_checks();
        chk("finished", polys_left, 0);
        chk("sb_empty", expq.size(), 0);
`ifdef REJ_SAMPLER_STATS_EN
        chk("rej_cnt",    rej_cnt,    mrej);
        chk("words_used", words_used, words_taken);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; coeff_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 64'h0; coeff_ready = 1'b1;
        rst_at = -1; stall_en = 0; rand_rdy = 0; rand_vld = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",    in_ready,    0);
        chk("reset_coeff_valid", coeff_valid, 0);
        chk("reset_coeff_data",  coeff_data,  0);
        chk("reset_coeff_idx",   coeff_idx,   0);
        chk("reset_busy",        busy,        0);
        chk("reset_done",        done,        0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_poly(2, 1, 0);
        end_checks();

        run_poly(3, 1, 0);
        end_checks();

        // All-ones candidates never pass the bound: 20 words drain with no output.
        run_poly(1, 1, 20);
        chk("ff_words", words_taken, 20);
        chk("ff_no_valid", valid_cycles, 0);
        chk("ff_busy", busy, 1);
        do_reset();

        // Two zero-stream polynomials, the second started in the done cycle.
        run_poly(0, 2, 0);
        end_checks();

        stall_en = 1;
        run_poly(4, 1, 0);
        end_checks();
        chk("stall_happened", stall_seen >= 8, 1);
        stall_en = 0;

        rand_rdy = 1; rand_vld = 1;
        run_poly(4, 1, 0);
        end_checks();
        rand_rdy = 0; rand_vld = 0;

        rst_at = 100;
        run_poly(0, 1, 0);
        chk("rst_abort_hit", aborted, 1);
        rst_at = -1;
        do_reset();
        run_poly(0, 1, 0);
        end_checks();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
